dist_gather9: RTL and testbench
===============================

# dist_gather9

Upstream gather stage for the 9-input density summer in the D2Q9 collision datapath. The block accepts the nine distribution values of one lattice node serially, one word per handshake, from the streaming/memory-read stage. It holds them in a 9-entry register bank and presents all nine in parallel, as Dout0..Dout8, with a valid/ready handshake to the downstream summer and equilibrium logic. It also checks per-node framing and flags malformed frames.

## Interface
- DATA_WIDTH, 32, width of each signed distribution value
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  signed distribution value f_i, i = 0..8 in arrival order
- in_valid  in  1  in_data/in_last valid this cycle
- in_last  in  1  marks the last word (f_8) of a node
- in_ready  out  1  block can accept a word this cycle
- Dout0..Dout8  out  DATA_WIDTH each  signed gathered values; Dout<i> = i-th accepted word of the frame
- out_valid  out  1  Dout0..Dout8 hold a complete frame
- out_ready  in  1  downstream consumes the frame this cycle
- frame_err  out  1  sticky framing-error flag; cleared only by Reset

## Operation
- The input transfer occurs on a cycle with in_valid && in_ready. The output transfer occurs on a cycle with out_valid && out_ready.
- A 4-bit word index idx counts 0..8. Each input transfer writes slot[idx] and increments idx.
- States (single-bank build): FILL and HOLD.
  - FILL: in_ready=1, out_valid=0.
  - A transfer with idx=8 writes slot 8, sets idx to 0 and moves to HOLD.
  - HOLD: in_ready=0, out_valid=1, and Dout0..8 are stable.
  - An output transfer in HOLD moves the block to FILL.
- Framing rules:
  - If in_last=1 on a transfer with idx<8, the frame is short. The block sets frame_err, discards the partial frame, resets idx to 0, stays in FILL and asserts no out_valid.
  - If in_last=0 on the transfer with idx=8, the block sets frame_err. The frame is still delivered, because delivery is count-based.
- Values are stored bit-exact; the block performs no arithmetic and no sign handling.
- Dout registers change only on input transfers into their own slot/bank. Between frames they hold their last values.
- While Reset=1: state=FILL, idx=0, out_valid=0, in_ready=0, frame_err=0 and Dout0..8=0. Both banks are reset in the double-buffered build.
- Reset asserted mid-frame or in HOLD drops all buffered data. No partial frame is ever emitted.

## Timing
- in_ready and out_valid are registered and derived only from state; there is no combinational path from in_valid or out_ready to either.
- Latency: out_valid rises on the cycle after the 9th input transfer.
- Single-bank throughput: at most one frame per 10 cycles.
  - After an output transfer in cycle t, in_ready=1 in cycle t+1.
  - There is no simultaneous accept and release.
- Words must be accepted back-to-back when in_valid is held high in FILL. Gaps (in_valid=0) are allowed anywhere in a frame.
- The first in_ready=1 appears in the first cycle after Reset deasserts.

## Configuration
- DIST_GATHER_DBUF_EN defined: two 9-entry banks used ping-pong (fill bank and hold bank).
  - in_ready=0 only when both banks are full.
  - out_valid=1 whenever at least one bank is full. Dout0..8 show the oldest full bank.
  - An input transfer and an output transfer may occur in the same cycle.
  - Sustained throughput is one frame per 9 cycles. Latency is unchanged at 1 cycle.
  - Frames are delivered in arrival order.
- DIST_GATHER_DBUF_EN undefined: the single-bank FILL/HOLD behaviour above, with no second bank logic.

## Test plan
- Reset, then stream words 1..9 (in_last on 9) with out_ready=1 → out_valid high the cycle after word 9, Dout0=1 … Dout8=9, frame_err=0.
- Hold out_ready=0 for 5 cycles after the frame completes → Dout stable and out_valid held throughout.
  - Single-bank build: in_ready=0.
  - Double-buffered build: in_ready=1 until a second frame (words 10..18) fills, then in_ready=0.
- Stream -1, -2, … -9 in two's complement with in_valid gaps → Dout0=-1 … Dout8=-9 bit-exact.
- Send 4 words with in_last on the 4th, then a valid 9-word frame of 0x100..0x108 → frame_err=1 (sticky), only one out_valid frame, Dout0=0x100.
- Send 9 words with in_last=0 on the 9th → frame delivered and frame_err=1.
- Assert Reset after the 5th word of a frame → next cycle out_valid=0, Dout=0, frame_err=0; a following full frame is delivered correctly.

Source files
------------

// File: rtl/dist_gather9_if.sv
// Bus bundle for dist_gather9. It carries the serial word input, the nine
// parallel gathered values, both valid/ready handshakes and the sticky
// framing-error flag.
// master: the side that streams words in and consumes frames (source/sink).
// slave:  the gather block itself.
interface dist_gather9_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] Dout0;
  logic [DATA_WIDTH-1:0] Dout1;
  logic [DATA_WIDTH-1:0] Dout2;
  logic [DATA_WIDTH-1:0] Dout3;
  logic [DATA_WIDTH-1:0] Dout4;
  logic [DATA_WIDTH-1:0] Dout5;
  logic [DATA_WIDTH-1:0] Dout6;
  logic [DATA_WIDTH-1:0] Dout7;
  logic [DATA_WIDTH-1:0] Dout8;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_valid, frame_err,
    input  Dout0, Dout1, Dout2, Dout3, Dout4, Dout5, Dout6, Dout7, Dout8
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_valid, frame_err,
    output Dout0, Dout1, Dout2, Dout3, Dout4, Dout5, Dout6, Dout7, Dout8
  );
endinterface

// File: rtl/dist_gather9.sv
// dist_gather9: gathers the nine distribution values of one D2Q9 lattice node,
// arriving one word per handshake, and presents them in parallel to the
// density summer. Values are stored bit-exact. Short frames (in_last before
// the ninth word) are dropped; a ninth word without in_last is still delivered.
// Either case sets the sticky frame_err flag, which only Reset clears.
// Build option: define DIST_GATHER_DBUF_EN for the ping-pong two-bank variant
// (accept and release in the same cycle, one frame per 9 cycles). Without it
// the block is a single bank with a FILL/HOLD state machine.
module dist_gather9 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  dist_gather9_if.slave io
);

  localparam int NSLOT = 9;

  logic [3:0]            idx;
  logic                  inReadyQ;
  logic                  outValidQ;
  logic                  frameErrQ;
  logic                  inXfer;
  logic                  outXfer;
  logic                  lastSlot;
  logic [DATA_WIDTH-1:0] doutSel [NSLOT];

  assign inXfer   = io.in_valid && inReadyQ;
  assign outXfer  = outValidQ && io.out_ready;
  assign lastSlot = (idx == 4'd8);

  assign io.in_ready  = inReadyQ;
  assign io.out_valid = outValidQ;
  assign io.frame_err = frameErrQ;
  assign io.Dout0     = doutSel[0];
  assign io.Dout1     = doutSel[1];
  assign io.Dout2     = doutSel[2];
  assign io.Dout3     = doutSel[3];
  assign io.Dout4     = doutSel[4];
  assign io.Dout5     = doutSel[5];
  assign io.Dout6     = doutSel[6];
  assign io.Dout7     = doutSel[7];
  assign io.Dout8     = doutSel[8];

  // Word index and framing check: a ninth word always closes the frame (count
  // based), an early in_last throws the partial frame away; both faults stick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx       <= '0;
      frameErrQ <= 1'b0;
    end else if (inXfer) begin
      if (lastSlot) begin
        idx <= '0;
        if (!io.in_last) begin
          frameErrQ <= 1'b1;
        end
      end else if (io.in_last) begin
        idx       <= '0;
        frameErrQ <= 1'b1;
      end else begin
        idx <= idx + 4'd1;
      end
    end
  end

`ifdef DIST_GATHER_DBUF_EN

  typedef enum logic [1:0] {
    EMPTY,
    ONE_FULL,
    BOTH_FULL
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic                  frameDone;
  logic                  wrBank;
  logic                  rdBank;
  logic [DATA_WIDTH-1:0] bank [2][NSLOT];

  assign frameDone = inXfer && lastSlot;

  // Number of full banks; handshake flags are registered from the next count
  // so neither in_ready nor out_valid sees in_valid/out_ready combinationally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= EMPTY;
      inReadyQ  <= 1'b0;
      outValidQ <= 1'b0;
    end else begin
      state     <= stateNext;
      inReadyQ  <= (stateNext != BOTH_FULL);
      outValidQ <= (stateNext != EMPTY);
    end
  end

  // Full-bank count moves up on a completed frame and down on a release;
  // both in one cycle leave it unchanged.
  always_comb begin
    stateNext = state;
    case (state)
      EMPTY: begin
        if (frameDone) begin
          stateNext = ONE_FULL;
        end
      end
      ONE_FULL: begin
        if (frameDone && !outXfer) begin
          stateNext = BOTH_FULL;
        end else if (!frameDone && outXfer) begin
          stateNext = EMPTY;
        end
      end
      BOTH_FULL: begin
        if (outXfer) begin
          stateNext = ONE_FULL;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  // Ping-pong pointers: the write bank flips when a frame completes, the read
  // bank flips when downstream takes a frame, so frames leave in arrival order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrBank <= 1'b0;
      rdBank <= 1'b0;
    end else begin
      if (frameDone) begin
        wrBank <= ~wrBank;
      end
      if (outXfer) begin
        rdBank <= ~rdBank;
      end
    end
  end

  // Both banks are cleared on reset; a word lands in its slot of the fill bank.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NSLOT; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else if (inXfer) begin
      bank[wrBank][idx] <= io.in_data;
    end
  end

  // Present the oldest full bank.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      doutSel[i] = bank[rdBank][i];
    end
  end

`else

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic [DATA_WIDTH-1:0] slot [NSLOT];

  // State register; the handshake flags are registered from the next state
  // and forced low while Reset is held.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= FILL;
      inReadyQ  <= 1'b0;
      outValidQ <= 1'b0;
    end else begin
      state     <= stateNext;
      inReadyQ  <= (stateNext == FILL);
      outValidQ <= (stateNext == HOLD);
    end
  end

  // FILL until the ninth word is taken, then HOLD until downstream takes it.
  always_comb begin
    stateNext = state;
    case (state)
      FILL: begin
        if (inXfer && lastSlot) begin
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (outXfer) begin
          stateNext = FILL;
        end
      end
      default: stateNext = FILL;
    endcase
  end

  // Slot bank: cleared on reset, otherwise each word lands in slot[idx].
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot[i] <= '0;
      end
    end else if (inXfer) begin
      slot[idx] <= io.in_data;
    end
  end

  // The slot registers drive the outputs directly.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      doutSel[i] = slot[i];
    end
  end

`endif

endmodule

// File: tb/tb_dist_gather9.sv
// Self-checking bench for dist_gather9 (single-bank build). A transaction-level
// model (queue of delivered frames, list of words of the current frame, last
// written value per slot) predicts in_ready, out_valid, frame_err and Dout0..8
// every cycle. Directed frames follow the test plan, then randomized frames.
module tb_dist_gather9;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  dist_gather9_if #(.DATA_WIDTH(32)) bus ();

  dist_gather9 #(.DATA_WIDTH(32)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .io   (bus)
  );

  always #5 Clk = ~Clk;

  typedef logic [31:0] frame_t [9];

  frame_t      frameQ [$];
  logic [31:0] curWords [$];
  logic [31:0] modelDout [9];
  logic        errExp;
  int          readyMode;
  int          checkCount;
  int          errorCount;
  logic [31:0] doutArr [9];

  always_comb begin
    doutArr[0] = bus.Dout0;
    doutArr[1] = bus.Dout1;
    doutArr[2] = bus.Dout2;
    doutArr[3] = bus.Dout3;
    doutArr[4] = bus.Dout4;
    doutArr[5] = bus.Dout5;
    doutArr[6] = bus.Dout6;
    doutArr[7] = bus.Dout7;
    doutArr[8] = bus.Dout8;
  end

  // Count a comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, note the handshakes that happen at the
  // edge, advance the model, then compare all outputs just after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                               input logic rst, output logic accepted);
    logic   released;
    frame_t frm;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    Reset        = rst;
    case (readyMode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 9) < 7);
    endcase
    accepted = !rst && v && (bus.in_ready === 1'b1);
    released = !rst && (bus.out_valid === 1'b1) && bus.out_ready;
    @(posedge Clk);
    #1;
    if (rst) begin
      frameQ.delete();
      curWords.delete();
      errExp = 1'b0;
      for (int i = 0; i < 9; i++) modelDout[i] = '0;
    end else begin
      if (released && frameQ.size() > 0) void'(frameQ.pop_front());
      if (accepted) begin
        modelDout[curWords.size()] = d;
        curWords.push_back(d);
        if (curWords.size() == 9) begin
          for (int i = 0; i < 9; i++) frm[i] = curWords[i];
          frameQ.push_back(frm);
          curWords.delete();
          if (!l) errExp = 1'b1;
        end else if (l) begin
          curWords.delete();
          errExp = 1'b1;
        end
      end
    end
    checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && frameQ.size() == 0)});
    checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, (frameQ.size() > 0)});
    checkOutput("frame_err", {31'd0, bus.frame_err}, {31'd0, errExp});
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("Dout%0d", i), doutArr[i], modelDout[i]);
    end
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic resetCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  // Offer one word until it is accepted, within a bounded number of cycles.
  task automatic sendWord(input logic [31:0] d, input logic l);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      applyStimulus(1'b1, d, l, 1'b0, acc);
      tries++;
    end
    checkOutput("word_accepted", {31'd0, acc}, 32'd1);
  endtask

  // Send n words base, base+step, ...; in_last on the n-th word if lastOnEnd.
  task automatic sendFrame(input logic [31:0] base, input logic [31:0] step,
                           input int n, input logic lastOnEnd, input logic gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
      sendWord(base + step * k, lastOnEnd && (k == n - 1));
    end
  endtask

  initial begin
    logic acc;
    int   kind;
    checkCount = 0;
    errorCount = 0;
    errExp     = 1'b0;
    readyMode  = 1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) modelDout[i] = '0;

    $display("[TB] reset and basic frame 1..9");
    resetCycles(3);
    sendFrame(32'd1, 32'd1, 9, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] hold frame with out_ready low");
    readyMode = 0;
    sendFrame(32'd10, 32'd1, 9, 1'b1, 1'b0);
    idleCycles(5);
    readyMode = 1;
    idleCycles(2);

    $display("[TB] negative values with gaps");
    sendFrame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 1'b1, 1'b1);
    idleCycles(2);

    $display("[TB] short frame then 0x100..0x108");
    sendFrame(32'd50, 32'd1, 4, 1'b1, 1'b0);
    sendFrame(32'h100, 32'd1, 9, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] nine words without in_last");
    sendFrame(32'h200, 32'd1, 9, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] reset mid-frame");
    sendFrame(32'h300, 32'd1, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
    sendFrame(32'h400, 32'd1, 9, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] randomized frames");
    readyMode = 2;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 19);
      if (kind < 14)      sendFrame($urandom, $urandom_range(1, 1000), 9, 1'b1, 1'b1);
      else if (kind < 17) sendFrame($urandom, $urandom_range(1, 1000), $urandom_range(1, 8), 1'b1, 1'b1);
      else                sendFrame($urandom, $urandom_range(1, 1000), 9, 1'b0, 1'b1);
      if (f == 20) begin
        resetCycles(1);
      end
    end
    readyMode = 1;
    idleCycles(3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
